// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module   : uart_pkg
// Purpose  : Shared UART rate/parity codes, 16x divisors and receiver states.
// Revision : 1.0
// ============================================================================
package uart_pkg;

    typedef enum logic [1:0] {
        BAUD_2400  = 2'b00,
        BAUD_4800  = 2'b01,
        BAUD_9600  = 2'b10,
        BAUD_19200 = 2'b11
    } baud_rate_t;

    typedef enum logic [1:0] {
        PARITY_NONE     = 2'b00,
        PARITY_ODD      = 2'b01,
        PARITY_EVEN     = 2'b10,
        PARITY_NONE_ALT = 2'b11
    } parity_t;

    // 50 MHz / (16 * baud), rounded
    localparam logic [10:0] c_DIV_2400  = 11'd1302;
    localparam logic [10:0] c_DIV_4800  = 11'd651;
    localparam logic [10:0] c_DIV_9600  = 11'd326;
    localparam logic [10:0] c_DIV_19200 = 11'd163;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } rx_state_t;

    function automatic logic [10:0] baud_divisor(input baud_rate_t rate);
        case (rate)
            BAUD_2400:  return c_DIV_2400;
            BAUD_4800:  return c_DIV_4800;
            BAUD_9600:  return c_DIV_9600;
            default:    return c_DIV_19200;
        endcase
    endfunction

endpackage
`default_nettype wire

// File: rtl/uart_rx_baud_gen.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_baud_gen
// Purpose  : 16x-oversample tick generator; held at zero while clear is high.
// Revision : 1.0
// ============================================================================
module uart_rx_baud_gen
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV_SHIFT = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       clear,
    input  baud_rate_t baud_rate,
    output logic       tick
);

    logic [10:0] r_cnt;
    logic [10:0] w_div;

    // A nonzero shift shortens every divisor equally for fast simulation.
    assign w_div = baud_divisor(baud_rate) >> BAUD_DIV_SHIFT;

    always_ff @(posedge clock) begin
        if (reset || clear) begin
            r_cnt <= '0;
            tick  <= 1'b0;
        end else if (r_cnt == w_div - 11'd1) begin
            r_cnt <= '0;
            tick  <= 1'b1;
        end else begin
            r_cnt <= r_cnt + 11'd1;
            tick  <= 1'b0;
        end
    end

endmodule
`default_nettype wire

// File: rtl/uart_rx_unit.sv
`default_nettype none
// ============================================================================
// Module   : uart_rx_unit
// Purpose  : UART receiver, 8 data bits, optional odd/even parity, 1 stop bit.
// Revision : 1.0
// ============================================================================
module uart_rx_unit
    import uart_pkg::*;
#(
    parameter int unsigned BAUD_DIV_SHIFT = 0
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       data_rx,
    input  logic [1:0] baud_rate,
    input  logic [1:0] parity_type,
    output logic [7:0] data_out,
    output logic       data_valid,
    output logic       parity_error,
    output logic       stop_error,
    output logic       active_flag,
    output logic       done_flag
);

    logic       r_sync1;
    logic       r_sync2;
    logic       r_rx_prev;
    logic [1:0] r_settle;
    logic       r_armed;
    rx_state_t  r_state;
    baud_rate_t r_baud;
    parity_t    r_parity;
    logic [3:0] r_tick_cnt;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_shift;
    logic       r_par_err;
    logic       r_stop_bit;
    logic       r_finish;

    logic       w_tick;
    logic       w_mid;
    logic       w_start_edge;
    logic       w_parity_en;
    logic       w_ones_odd;

    uart_rx_baud_gen #(
        .BAUD_DIV_SHIFT (BAUD_DIV_SHIFT)
    ) u_baud_gen (
        .clock     (clock),
        .reset     (reset),
        .clear     (r_state == ST_IDLE),
        .baud_rate (r_baud),
        .tick      (w_tick)
    );

    // Start bit is checked at its 8th tick; later bits every 16 ticks after that.
    assign w_mid        = w_tick && ((r_state == ST_START) ? (r_tick_cnt == 4'd7)
                                                           : (r_tick_cnt == 4'd15));
    assign w_start_edge = r_armed && r_rx_prev && !r_sync2;
    assign w_parity_en  = (r_parity == PARITY_ODD) || (r_parity == PARITY_EVEN);
    assign w_ones_odd   = ^{r_shift, r_sync2};

    always_ff @(posedge clock) begin
        if (reset) begin
            r_sync1      <= 1'b1;
            r_sync2      <= 1'b1;
            r_rx_prev    <= 1'b1;
            r_settle     <= '0;
            r_armed      <= 1'b0;
            r_state      <= ST_IDLE;
            r_baud       <= BAUD_2400;
            r_parity     <= PARITY_NONE;
            r_tick_cnt   <= '0;
            r_bit_cnt    <= '0;
            r_shift      <= '0;
            r_par_err    <= 1'b0;
            r_stop_bit   <= 1'b1;
            r_finish     <= 1'b0;
            data_out     <= 8'h00;
            data_valid   <= 1'b0;
            parity_error <= 1'b0;
            stop_error   <= 1'b0;
            active_flag  <= 1'b0;
            done_flag    <= 1'b0;
        end else begin
            r_sync1    <= data_rx;
            r_sync2    <= r_sync1;
            r_rx_prev  <= r_sync2;
            if (r_settle != 2'd3) r_settle <= r_settle + 2'd1;

            data_valid <= 1'b0;
            done_flag  <= 1'b0;
            r_finish   <= 1'b0;
            if (r_finish) begin
                data_out     <= r_shift;
                parity_error <= r_par_err;
                stop_error   <= ~r_stop_bit;
                data_valid   <= 1'b1;
                done_flag    <= 1'b1;
                active_flag  <= 1'b0;
            end

            if (w_tick) r_tick_cnt <= r_tick_cnt + 4'd1;

            case (r_state)
                ST_IDLE: begin
                    r_tick_cnt <= '0;
                    r_bit_cnt  <= '0;
                    // Re-arm only once the synchronizer holds real line data showing idle.
                    if (!r_armed) begin
                        if ((r_settle == 2'd3) && r_sync2) r_armed <= 1'b1;
                    end else if (w_start_edge) begin
                        r_state   <= ST_START;
                        r_baud    <= baud_rate_t'(baud_rate);
                        r_parity  <= parity_t'(parity_type);
                        r_par_err <= 1'b0;
                    end
                end
                ST_START: begin
                    if (w_mid) begin
                        r_tick_cnt <= '0;
                        if (!r_sync2) begin
                            r_state     <= ST_DATA;
                            active_flag <= 1'b1;
                        end else begin
                            r_state <= ST_IDLE;
                        end
                    end
                end
                ST_DATA: begin
                    if (w_mid) begin
                        r_shift   <= {r_sync2, r_shift[7:1]};
                        r_bit_cnt <= r_bit_cnt + 3'd1;
                        if (r_bit_cnt == 3'd7) r_state <= w_parity_en ? ST_PARITY : ST_STOP;
                    end
                end
                ST_PARITY: begin
                    if (w_mid) begin
                        r_par_err <= (r_parity == PARITY_ODD) ? ~w_ones_odd : w_ones_odd;
                        r_state   <= ST_STOP;
                    end
                end
                ST_STOP: begin
                    if (w_mid) begin
                        r_stop_bit <= r_sync2;
                        r_finish   <= 1'b1;
                        r_state    <= ST_IDLE;
                        if (!r_sync2) r_armed <= 1'b0;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
